// File: rtl/dac_spi_tx.sv
// SPI transmitter for a 10-bit DAC: builds a 16-bit control+data frame, shifts it out MSB first,
// then pulses the latch strobe. A one-deep pending buffer lets frames run back to back.
module dac_spi_tx #(
  parameter int unsigned CLK_DIV = 25,
  parameter logic        BUF     = 1'b0,
  parameter logic        GA_N    = 1'b1
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [9:0] data_in,
  input  logic       load,
  output logic       dac_cs,
  output logic       dac_sck,
  output logic       dac_sdi,
  output logic       dac_ld,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_e;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  function automatic logic [15:0] make_frame(input logic [9:0] code);
    return {1'b0, BUF, GA_N, 1'b1, code, 2'b00};
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  half_q, half_d;
  logic [15:0] shreg_q, shreg_d;
  logic        pend_q, pend_d;
  logic [9:0]  pend_data_q, pend_data_d;
  logic        cs_q, cs_d;
  logic        sck_q, sck_d;
  logic        sdi_q, sdi_d;
  logic        ld_q, ld_d;

  logic        div_end;
  logic        start;
  logic [9:0]  start_code;
  logic [15:0] start_frame;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    div_d       = div_q;
    half_d      = half_q;
    shreg_d     = shreg_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    cs_d        = cs_q;
    sck_d       = sck_q;
    sdi_d       = sdi_q;
    ld_d        = ld_q;
    start       = 1'b0;
    start_code  = data_in;
    div_end     = (div_q == DIV_LAST);

    case (state_q)
      IDLE: begin
        start = load;
      end
      SHIFT: begin
        if (load) begin
          pend_d      = 1'b1;
          pend_data_d = data_in;
        end
        div_d = div_q + 8'd1;
        if (div_end) begin
          div_d  = 8'd0;
          half_d = half_q + 5'd1;
          if (half_q == 5'd31) begin
            state_d = LATCH;
            half_d  = 5'd0;
            sck_d   = 1'b0;
            cs_d    = 1'b1;
            sdi_d   = 1'b0;
            ld_d    = 1'b0;
          end else begin
            sck_d = ~sck_q;
            // Data advances only on the falling SCK edge so the DAC samples a stable bit.
            if (sck_q) begin
              shreg_d = shreg_q << 1;
              sdi_d   = shreg_q[14];
            end
          end
        end
      end
      LATCH: begin
        div_d = div_q + 8'd1;
        if (div_end) begin
          div_d = 8'd0;
          ld_d  = 1'b1;
          if (load || pend_q) begin
            start      = 1'b1;
            start_code = load ? data_in : pend_data_q;
          end else begin
            state_d = IDLE;
          end
        end else if (load) begin
          pend_d      = 1'b1;
          pend_data_d = data_in;
        end
      end
      default: state_d = IDLE;
    endcase

    start_frame = make_frame(start_code);
    if (start) begin
      state_d = SHIFT;
      shreg_d = start_frame;
      sdi_d   = start_frame[15];
      cs_d    = 1'b0;
      sck_d   = 1'b0;
      div_d   = 8'd0;
      half_d  = 5'd0;
      pend_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      div_q       <= 8'd0;
      half_q      <= 5'd0;
      shreg_q     <= 16'd0;
      pend_q      <= 1'b0;
      pend_data_q <= 10'd0;
      cs_q        <= 1'b1;
      sck_q       <= 1'b0;
      sdi_q       <= 1'b0;
      ld_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      half_q      <= half_d;
      shreg_q     <= shreg_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      cs_q        <= cs_d;
      sck_q       <= sck_d;
      sdi_q       <= sdi_d;
      ld_q        <= ld_d;
    end
  end

  assign dac_cs  = cs_q;
  assign dac_sck = sck_q;
  assign dac_sdi = sdi_q;
  assign dac_ld  = ld_q;
  assign busy    = (state_q != IDLE) || pend_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: frame content, timing, pending buffer, reset abort, default divider.
module tb_dac_spi_tx;

  logic       sysclk = 1'b0;
  logic       reset;
  logic [9:0] data_in;
  logic       load;
  logic       dac_cs, dac_sck, dac_sdi, dac_ld, busy;

  logic [9:0] data25;
  logic       load25;
  logic       cs25, sck25, sdi25, ld25, busy25;

  int total = 0;
  int bad   = 0;

  always #5 sysclk = ~sysclk;

  dac_spi_tx #(.CLK_DIV(2), .BUF(1'b0), .GA_N(1'b1)) dut (
    .sysclk(sysclk), .reset(reset), .data_in(data_in), .load(load),
    .dac_cs(dac_cs), .dac_sck(dac_sck), .dac_sdi(dac_sdi), .dac_ld(dac_ld), .busy(busy)
  );

  dac_spi_tx dut25 (
    .sysclk(sysclk), .reset(reset), .data_in(data25), .load(load25),
    .dac_cs(cs25), .dac_sck(sck25), .dac_sdi(sdi25), .dac_ld(ld25), .busy(busy25)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive the load cycle; the rising edge ending it is the reference edge E0.
  task automatic kick(input logic [9:0] code);
    @(negedge sysclk);
    check("busy before load", busy, 1'b0);
    load    = 1'b1;
    data_in = code;
  endtask

  // Runs cycles n=1.. after E0 until busy drops, optionally injecting loads at cycles k1/k2.
  task automatic run(input int max, input int k1, input logic [9:0] d1,
                     input int k2, input logic [9:0] d2, input int probe,
                     output logic [31:0] bits, output int nbits, output int cs_low,
                     output int ld_low, output int busy_cyc, output int sdi_viol,
                     output logic first_busy, output logic probe_cs, output logic timeout);
    logic prev_sck, prev_sdi, prev_cs;
    bits = '0; nbits = 0; cs_low = 0; ld_low = 0; busy_cyc = 0; sdi_viol = 0;
    first_busy = 1'b0; probe_cs = 1'bx; timeout = 1'b1;
    prev_sck = 1'b0; prev_sdi = 1'b0; prev_cs = 1'b1;
    for (int n = 1; n <= max; n++) begin
      @(negedge sysclk);
      load    = (n == k1) || (n == k2);
      data_in = (n == k1) ? d1 : (n == k2) ? d2 : 10'($urandom);
      if (n == 1) first_busy = busy;
      if (n == probe) probe_cs = dac_cs;
      if (!busy) begin
        timeout = 1'b0;
        break;
      end
      busy_cyc++;
      if (!dac_cs) cs_low++;
      if (!dac_ld) ld_low++;
      if (dac_sck && !prev_sck) begin
        bits = {bits[30:0], dac_sdi};
        nbits++;
      end
      if (!dac_cs && !prev_cs && dac_sdi !== prev_sdi && !(prev_sck && !dac_sck)) sdi_viol++;
      prev_sck = dac_sck; prev_sdi = dac_sdi; prev_cs = dac_cs;
    end
    load = 1'b0;
  endtask

  logic [31:0] bits;
  int          nbits, cs_low, ld_low, busy_cyc, sdi_viol;
  logic        first_busy, probe_cs, timeout;

  initial begin
    reset = 1'b1; load = 1'b0; data_in = '0; load25 = 1'b0; data25 = '0;
    repeat (3) @(negedge sysclk);
    check("reset cs", dac_cs, 1'b1);
    check("reset sck", dac_sck, 1'b0);
    check("reset sdi", dac_sdi, 1'b0);
    check("reset ld", dac_ld, 1'b1);
    check("reset busy", busy, 1'b0);
    reset = 1'b0;

    // Single frame, code 2A5
    kick(10'h2A5);
    run(300, -1, '0, -1, '0, -1, bits, nbits, cs_low, ld_low, busy_cyc, sdi_viol, first_busy, probe_cs, timeout);
    check("2A5 timeout", timeout, 1'b0);
    check("2A5 frame", bits[15:0], 16'h3A94);
    check("2A5 nbits", nbits, 16);
    check("2A5 cs low", cs_low, 64);
    check("2A5 ld low", ld_low, 2);
    check("2A5 latency", busy_cyc + 1, 67);
    check("2A5 busy rise", first_busy, 1'b1);
    check("2A5 sdi edges", sdi_viol, 0);

    // Boundary codes
    kick(10'h000);
    run(300, -1, '0, -1, '0, -1, bits, nbits, cs_low, ld_low, busy_cyc, sdi_viol, first_busy, probe_cs, timeout);
    check("000 frame", bits[15:0], 16'h3000);
    check("000 nbits", nbits, 16);
    kick(10'h3FF);
    run(300, -1, '0, -1, '0, -1, bits, nbits, cs_low, ld_low, busy_cyc, sdi_viol, first_busy, probe_cs, timeout);
    check("3FF frame", bits[15:0], 16'h3FFC);
    check("3FF sdi edges", sdi_viol, 0);

    // Pending buffer: last mid-frame load wins, no idle gap
    kick(10'h100);
    run(400, 10, 10'h155, 40, 10'h0AA, -1, bits, nbits, cs_low, ld_low, busy_cyc, sdi_viol, first_busy, probe_cs, timeout);
    check("pend timeout", timeout, 1'b0);
    check("pend bits", bits, 32'h3400_32A8);
    check("pend nbits", nbits, 32);
    check("pend busy", busy_cyc, 132);
    check("pend cs low", cs_low, 128);
    check("pend ld low", ld_low, 4);

    // Load on the last LATCH cycle starts the next frame immediately
    kick(10'h2A5);
    run(400, 66, 10'h3FF, -1, '0, 67, bits, nbits, cs_low, ld_low, busy_cyc, sdi_viol, first_busy, probe_cs, timeout);
    check("lastlatch cs", probe_cs, 1'b0);
    check("lastlatch bits", bits, 32'h3A94_3FFC);
    check("lastlatch busy", busy_cyc, 132);

    // Asynchronous reset at bit 7
    kick(10'h2A5);
    @(negedge sysclk);
    load = 1'b0;
    repeat (27) @(negedge sysclk);
    check("pre-reset sck", dac_sck, 1'b1);
    check("pre-reset cs", dac_cs, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async cs", dac_cs, 1'b1);
    check("async sck", dac_sck, 1'b0);
    check("async sdi", dac_sdi, 1'b0);
    check("async ld", dac_ld, 1'b1);
    check("async busy", busy, 1'b0);
    repeat (2) @(negedge sysclk);
    reset = 1'b0;
    ld_low = 0; busy_cyc = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge sysclk);
      if (!dac_ld) ld_low++;
      if (busy) busy_cyc++;
    end
    check("abort ld pulse", ld_low, 0);
    check("abort busy", busy_cyc, 0);
    kick(10'h155);
    run(300, -1, '0, -1, '0, -1, bits, nbits, cs_low, ld_low, busy_cyc, sdi_viol, first_busy, probe_cs, timeout);
    check("post-reset frame", bits[15:0], 16'h3554);
    check("post-reset ld low", ld_low, 2);

    // Default divider instance
    begin
      int   rise1, rise2, busy25_cyc, n25;
      logic prev;
      logic [15:0] b25;
      logic to25;
      rise1 = -1; rise2 = -1; busy25_cyc = 0; n25 = 0; prev = 1'b0; b25 = '0; to25 = 1'b1;
      @(negedge sysclk);
      load25 = 1'b1; data25 = 10'h2A5;
      for (int n = 1; n <= 1000; n++) begin
        @(negedge sysclk);
        load25 = 1'b0;
        data25 = 10'($urandom);
        if (!busy25) begin
          to25 = 1'b0;
          break;
        end
        busy25_cyc++;
        if (sck25 && !prev) begin
          if (rise1 < 0) rise1 = n;
          else if (rise2 < 0) rise2 = n;
          b25 = {b25[14:0], sdi25};
          n25++;
        end
        prev = sck25;
      end
      check("div25 timeout", to25, 1'b0);
      check("div25 sck period", rise2 - rise1, 50);
      check("div25 frame time", busy25_cyc + 1, 826);
      check("div25 frame", b25, 16'h3A94);
      check("div25 nbits", n25, 16);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
